// File: rtl/alu_cmd_issuer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_cmd_issuer_pkg                                                         |
// | Shared state encoding, condition codes, ALU op codes and flag indices.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_cmd_issuer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_FLAG = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam int FUNSEL_W = 5;
    localparam int FLAGS_W  = 4;
    localparam int COND_W   = 3;

    localparam logic [COND_W-1:0] COND_ALWAYS = 3'd0;
    localparam logic [COND_W-1:0] COND_Z      = 3'd1;
    localparam logic [COND_W-1:0] COND_NZ     = 3'd2;
    localparam logic [COND_W-1:0] COND_C      = 3'd3;
    localparam logic [COND_W-1:0] COND_NC     = 3'd4;
    localparam logic [COND_W-1:0] COND_N      = 3'd5;
    localparam logic [COND_W-1:0] COND_O      = 3'd6;
    localparam logic [COND_W-1:0] COND_NEVER  = 3'd7;

    // Low four FunSel bits; bit 4 only chooses 8- or 16-bit width.
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_NAND = 4'b1010;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    function automatic logic is_wide(input logic [FUNSEL_W-1:0] fun_sel);
        return fun_sel[FUNSEL_W-1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_issuer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_cmd_issuer_if                                                          |
// | Command, ALU and response signals of the issuer, with both-side modports. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface alu_cmd_issuer_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [4:0]        cmd_fun_sel;
    logic              cmd_wf;
    logic [2:0]        cmd_cond;

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [4:0]        fun_sel;
    logic              wf;
    logic [DATA_W-1:0] alu_out;
    logic [3:0]        flags_out;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic [3:0]        rsp_flags;
    logic              rsp_cond_true;
    logic [CNT_W-1:0]  op_count;

    // Control unit and ALU side.
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_fun_sel, cmd_wf, cmd_cond,
        output alu_out, flags_out, rsp_ready,
        input  cmd_ready, a, b, fun_sel, wf,
        input  rsp_valid, rsp_result, rsp_flags, rsp_cond_true, op_count
    );

    // Issuer side.
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_fun_sel, cmd_wf, cmd_cond,
        input  alu_out, flags_out, rsp_ready,
        output cmd_ready, a, b, fun_sel, wf,
        output rsp_valid, rsp_result, rsp_flags, rsp_cond_true, op_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_issuer_cond_eval.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_cond_eval                                                              |
// | Combinational evaluation of a 3-bit condition code on {Z,C,N,O} flags.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_cond_eval
    import alu_cmd_issuer_pkg::*;
(
    input  logic [COND_W-1:0]  cond,
    input  logic [FLAGS_W-1:0] flags,
    output logic               cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_ALWAYS: cond_true = 1'b1;
            COND_Z:      cond_true = flags[FLAG_Z];
            COND_NZ:     cond_true = ~flags[FLAG_Z];
            COND_C:      cond_true = flags[FLAG_C];
            COND_NC:     cond_true = ~flags[FLAG_C];
            COND_N:      cond_true = flags[FLAG_N];
            COND_O:      cond_true = flags[FLAG_O];
            COND_NEVER:  cond_true = 1'b0;
            default:     cond_true = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_cmd_issuer                                                             |
// | Issues one ALU command, pulses WF for one edge, returns result and flags. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_cmd_issuer
    import alu_cmd_issuer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    alu_cmd_issuer_if.slave    bus
);

    state_t              r_state;
    state_t              w_next_state;
    logic                w_accept;

    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [FUNSEL_W-1:0] r_fun_sel;
    logic                r_wf;
    logic [COND_W-1:0]   r_cond;

    logic [DATA_W-1:0]   r_result;
    logic [FLAGS_W-1:0]  r_flags;
    logic                r_cond_true;
    logic [CNT_W-1:0]    r_op_count;

    logic [DATA_W-1:0]   w_result;
    logic                w_cond_true;

    alu_cond_eval u_cond_eval (
        .cond      (r_cond),
        .flags     (bus.flags_out),
        .cond_true (w_cond_true)
    );

    // 8-bit ops return only the low byte; upper ALU bits are not meaningful.
    assign w_result = is_wide(r_fun_sel) ? bus.alu_out
                                         : {{(DATA_W-8){1'b0}}, bus.alu_out[7:0]};

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: w_next_state = ST_FLAG;
            ST_FLAG: w_next_state = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_fun_sel   <= '0;
            r_wf        <= 1'b0;
            r_cond      <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_cond_true <= 1'b0;
            r_op_count  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_a       <= bus.cmd_a;
                r_b       <= bus.cmd_b;
                r_fun_sel <= bus.cmd_fun_sel;
                r_wf      <= bus.cmd_wf;
                r_cond    <= bus.cmd_cond;
            end
            if (r_state == ST_EXEC) begin
                r_result <= w_result;
            end
            // Flag register inside the ALU has settled by the FLAG cycle.
            if (r_state == ST_FLAG) begin
                r_flags     <= bus.flags_out;
                r_cond_true <= w_cond_true;
            end
            if ((r_state == ST_RESP) && bus.rsp_ready) begin
                r_op_count <= r_op_count + 1'b1;
            end
        end
    end

    assign bus.cmd_ready     = (r_state == ST_IDLE) && !rst;
    assign bus.wf            = (r_state == ST_EXEC) && r_wf && !rst;
    assign bus.a             = r_a;
    assign bus.b             = r_b;
    assign bus.fun_sel       = r_fun_sel;
    assign bus.rsp_valid     = (r_state == ST_RESP);
    assign bus.rsp_result    = r_result;
    assign bus.rsp_flags     = r_flags;
    assign bus.rsp_cond_true = r_cond_true;
    assign bus.op_count      = r_op_count;

endmodule
`default_nettype wire
